// File: rtl/stereo_window_gen.sv
// stereo_window_gen: lockstep left/right raster pixels in, paired 3x3 windows out.
// Two ping-pong line buffers per image (selected by row parity) hold the two
// previous lines; a 2-deep column shift register completes each window.
module stereo_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COORD_W    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_pixels_valid,
    input  logic               i_sof,
    input  logic [7:0]         i_left_pixel,
    input  logic [7:0]         i_right_pixel,
    output logic [71:0]        o_kernel1_data,
    output logic [71:0]        o_kernel2_data,
    output logic               o_kernels_valid,
    output logic [COORD_W-1:0] o_center_x,
    output logic [COORD_W-1:0] o_center_y,
    output logic               o_frame_done
);
    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {WAIT_SOF, FILL, STREAM} state_t;

    state_t             r_state, w_state_nxt;
    logic [COORD_W-1:0] r_row, r_col;
    logic [COORD_W-1:0] w_row_eff, w_col_eff, w_row_nxt, w_col_nxt;
    logic               w_accept, w_emit, w_last;
    logic [AW-1:0]      w_addr;

    // Line buffers: buffer [row%2] holds line r-2 until overwritten by line r.
    logic [7:0] r_lb_l0 [IMG_WIDTH];
    logic [7:0] r_lb_l1 [IMG_WIDTH];
    logic [7:0] r_lb_r0 [IMG_WIDTH];
    logic [7:0] r_lb_r1 [IMG_WIDTH];

    // Stage 1: buffered column plus sideband for the accepted pixel.
    logic               r_v1, r_emit1, r_last1;
    logic [COORD_W-1:0] r_cx1, r_cy1;
    logic [7:0]         r_lbot1, r_lmid1, r_ltop1;
    logic [7:0]         r_rbot1, r_rmid1, r_rtop1;

    // Column shift registers, {bottom, middle, top}: sh0 = col c-2, sh1 = col c-1.
    logic [23:0] r_lsh0, r_lsh1, r_rsh0, r_rsh1;
    logic [23:0] w_lcol, w_rcol;

    assign w_addr = w_col_eff[AW-1:0];
    assign w_lcol = {r_lbot1, r_lmid1, r_ltop1};
    assign w_rcol = {r_rbot1, r_rmid1, r_rtop1};

    // State register and raster counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_SOF;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

    // Accept/emit decision, effective position (sof forces 0,0) and next state.
    always_comb begin
        w_accept    = 1'b0;
        w_emit      = 1'b0;
        w_last      = 1'b0;
        w_row_eff   = r_row;
        w_col_eff   = r_col;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_state_nxt = r_state;
        if (i_pixels_valid) begin
            if (i_sof) begin
                w_accept  = 1'b1;
                w_row_eff = '0;
                w_col_eff = '0;
            end else if (r_state != WAIT_SOF) begin
                w_accept = 1'b1;
            end
        end
        if (w_accept) begin
            w_last = (w_row_eff == LAST_ROW) && (w_col_eff == LAST_COL);
            w_emit = (r_state == STREAM) && !i_sof && (w_col_eff >= COORD_W'(2));
            if (w_col_eff == LAST_COL) begin
                w_col_nxt = '0;
                w_row_nxt = w_row_eff + COORD_W'(1);
            end else begin
                w_col_nxt = w_col_eff + COORD_W'(1);
                w_row_nxt = w_row_eff;
            end
            if (w_last) begin
                w_state_nxt = WAIT_SOF;
                w_row_nxt   = '0;
                w_col_nxt   = '0;
            end else if (w_row_eff == COORD_W'(1) && w_col_eff == LAST_COL) begin
                w_state_nxt = STREAM;
            end else if (i_sof) begin
                w_state_nxt = FILL;
            end
        end
    end

    // Line buffer writes; the stage-1 reads below see the pre-write contents.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (w_row_eff[0]) begin
                r_lb_l1[w_addr] <= i_left_pixel;
                r_lb_r1[w_addr] <= i_right_pixel;
            end else begin
                r_lb_l0[w_addr] <= i_left_pixel;
                r_lb_r0[w_addr] <= i_right_pixel;
            end
        end
    end

    // Stage 1: synchronous line buffer read and sideband capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_emit1 <= 1'b0;
            r_last1 <= 1'b0;
            r_cx1   <= '0;
            r_cy1   <= '0;
            r_lbot1 <= '0; r_lmid1 <= '0; r_ltop1 <= '0;
            r_rbot1 <= '0; r_rmid1 <= '0; r_rtop1 <= '0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_emit1 <= w_emit;
                r_last1 <= w_last;
                r_cx1   <= w_col_eff - COORD_W'(1);
                r_cy1   <= w_row_eff - COORD_W'(1);
                r_lbot1 <= i_left_pixel;
                r_rbot1 <= i_right_pixel;
                r_ltop1 <= w_row_eff[0] ? r_lb_l1[w_addr] : r_lb_l0[w_addr];
                r_lmid1 <= w_row_eff[0] ? r_lb_l0[w_addr] : r_lb_l1[w_addr];
                r_rtop1 <= w_row_eff[0] ? r_lb_r1[w_addr] : r_lb_r0[w_addr];
                r_rmid1 <= w_row_eff[0] ? r_lb_r0[w_addr] : r_lb_r1[w_addr];
            end
        end
    end

    // Stage 2: shift columns, assemble packed windows, drive registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lsh0 <= '0; r_lsh1 <= '0; r_rsh0 <= '0; r_rsh1 <= '0;
            o_kernel1_data  <= '0;
            o_kernel2_data  <= '0;
            o_kernels_valid <= 1'b0;
            o_center_x      <= '0;
            o_center_y      <= '0;
            o_frame_done    <= 1'b0;
        end else begin
            o_kernels_valid <= r_v1 && r_emit1;
            o_frame_done    <= r_v1 && r_last1;
            if (r_v1) begin
                r_lsh0 <= r_lsh1;
                r_lsh1 <= w_lcol;
                r_rsh0 <= r_rsh1;
                r_rsh1 <= w_rcol;
                if (r_emit1) begin
                    o_kernel1_data <= {w_lcol[23:16], r_lsh1[23:16], r_lsh0[23:16],
                                       w_lcol[15:8],  r_lsh1[15:8],  r_lsh0[15:8],
                                       w_lcol[7:0],   r_lsh1[7:0],   r_lsh0[7:0]};
                    o_kernel2_data <= {w_rcol[23:16], r_rsh1[23:16], r_rsh0[23:16],
                                       w_rcol[15:8],  r_rsh1[15:8],  r_rsh0[15:8],
                                       w_rcol[7:0],   r_rsh1[7:0],   r_rsh0[7:0]};
                    o_center_x <= r_cx1;
                    o_center_y <= r_cy1;
                end
            end
        end
    end
endmodule

// File: tb/tb_stereo_window_gen.sv
// Directed bench for stereo_window_gen on a 4x4 frame: pixel = base + 4r + c
// (right image adds 100). Expected windows are queued with their due cycle.
module tb_stereo_window_gen;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid, sof;
    logic [7:0]    lp, rp;
    logic [71:0]   k1, k2;
    logic          kv, fdone;
    logic [CW-1:0] cx, cy;

    stereo_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COORD_W(CW)) dut (
        .clk(clk), .rst(rst),
        .i_pixels_valid(valid), .i_sof(sof),
        .i_left_pixel(lp), .i_right_pixel(rp),
        .o_kernel1_data(k1), .o_kernel2_data(k2), .o_kernels_valid(kv),
        .o_center_x(cx), .o_center_y(cy), .o_frame_done(fdone)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [71:0] k1, k2;
        int cx, cy;
        bit done;
        int at;
    } exp_t;

    exp_t q[$];
    int n_chk = 0, n_fail = 0, n_win = 0, n_exp = 0, n_done = 0;
    logic [71:0] first_k1, first_k2;
    int first_cx, first_cy;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] win(input int base, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = 8'(base + 4*(r-2+i) + (c-2+j));
        return w;
    endfunction

    // Output monitor: every window must match the head of the expected queue.
    always @(negedge clk) begin
        if (kv) begin
            if (n_win == 0) begin
                first_k1 = k1; first_k2 = k2;
                first_cx = int'(cx); first_cy = int'(cy);
            end
            n_win++;
            if (fdone) n_done++;
            if (q.size() == 0) chk("spurious_win", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("k1", k1, e.k1);
                chk("k2", k2, e.k2);
                chk("cx", 72'(cx), 72'(e.cx));
                chk("cy", 72'(cy), 72'(e.cy));
                chk("done", 72'(fdone), 72'(e.done));
                chk("latency", 72'(cyc), 72'(e.at));
            end
        end else if (fdone) begin
            chk("lone_done", 1, 0);
        end
    end

    task automatic px(input bit s, input int base, input int r, input int c,
                      input bit w, input bit d);
        exp_t e;
        @(negedge clk);
        valid = 1'b1;
        sof   = s;
        lp    = 8'(base + 4*r + c);
        rp    = 8'(base + 100 + 4*r + c);
        if (w) begin
            e.k1 = win(base, r, c);
            e.k2 = win(base + 100, r, c);
            e.cx = c - 1;
            e.cy = r - 1;
            e.done = d;
            e.at = cyc + 2;
            q.push_back(e);
            n_exp++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid = 1'b0;
            sof   = 1'($urandom);
            lp    = 8'($urandom);
            rp    = 8'($urandom);
        end
    endtask

    task automatic frame(input int base, input bit gaps, input int n);
        for (int idx = 0; idx < n; idx++) begin
            int r, c;
            r = idx / W;
            c = idx % W;
            px(idx == 0, base, r, c, (r >= 2) && (c >= 2), idx == W*H-1);
            if (gaps) begin
                idle(1);
                if ($urandom_range(0, 3) == 0) idle(3);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_k1"}, k1, 0);
        chk({tag, "_k2"}, k2, 0);
        chk({tag, "_kv"}, 72'(kv), 0);
        chk({tag, "_cx"}, 72'(cx), 0);
        chk({tag, "_cy"}, 72'(cy), 0);
        chk({tag, "_fd"}, 72'(fdone), 0);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; sof = 1'b0; lp = '0; rp = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // Stray pixels before any sof, then a clean continuous frame.
        repeat (5) begin
            @(negedge clk);
            valid = 1'b1; sof = 1'b0;
            lp = 8'($urandom); rp = 8'($urandom);
        end
        frame(0, 1'b0, W*H);
        idle(4);
        chk("A_wins", 72'(n_win), 4);
        chk("A_done", 72'(n_done), 1);
        chk("A_first_k1", first_k1, 72'h0A0908060504020100);
        chk("A_first_k2", first_k2, 72'h6E6D6C6A6968666564);
        chk("A_first_cx", 72'(first_cx), 1);
        chk("A_first_cy", 72'(first_cy), 1);

        // Same frame with bubbles on the input.
        frame(0, 1'b1, W*H);
        idle(4);
        chk("B_wins", 72'(n_win), 8);
        chk("B_done", 72'(n_done), 2);

        // Restart at (2,3): only the (2,2) window of the old frame survives.
        frame(0, 1'b0, 11);
        frame(50, 1'b0, W*H);
        idle(4);
        chk("C_wins", 72'(n_win), 13);
        chk("C_done", 72'(n_done), 3);

        // Reset at pixel (3,1); the frame tail is then ignored.
        frame(0, 1'b0, 13);
        @(negedge clk);
        rst = 1'b1; valid = 1'b1; sof = 1'b0;
        lp = 8'(13); rp = 8'(113);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        chk_zero("midrst");
        px(1'b0, 0, 3, 2, 1'b0, 1'b0);
        px(1'b0, 0, 3, 3, 1'b0, 1'b0);
        idle(2);
        frame(20, 1'b0, W*H);
        idle(4);
        chk("D_wins", 72'(n_win), 19);
        chk("D_done", 72'(n_done), 4);

        // Back-to-back frames.
        frame(0, 1'b0, W*H);
        frame(30, 1'b0, W*H);
        idle(5);
        chk("E_wins", 72'(n_win), 27);
        chk("E_done", 72'(n_done), 6);

        chk("total_wins", 72'(n_win), 72'(n_exp));
        chk("queue_empty", 72'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stereo_window_gen.md
Name: stereo_window_gen

Overview:
- Streaming front end that feeds the SAD pipeline.
- Accepts lockstep left/right 8-bit pixel streams in raster order and keeps two line buffers per image.
- Emits paired 3x3 windows in the exact 72-bit packing the SAD stage consumes, with one valid strobe and the window-centre coordinates.
- Sits between the pixel DMA/receiver and the per-disparity SAD instances.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=4).
- IMG_HEIGHT, 480, lines per frame (>=3).
- COORD_W, 10, width of coordinate outputs; must satisfy 2^COORD_W >= max(IMG_WIDTH, IMG_HEIGHT).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_pixels_valid  in  1  both pixel inputs valid this cycle.
- i_sof  in  1  qualifies the current pixel as frame start (row 0, col 0); only meaningful with i_pixels_valid.
- i_left_pixel  in  8  left image pixel.
- i_right_pixel  in  8  right image pixel.
- o_kernel1_data  out  72  left 3x3 window.
- o_kernel2_data  out  72  right 3x3 window, same position as kernel1.
- o_kernels_valid  out  1  windows valid, single-cycle strobe per window.
- o_center_x  out  COORD_W  window centre column.
- o_center_y  out  COORD_W  window centre row.
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Reset: all outputs 0; state WAIT_SOF; row/col counters 0; window registers 0. Line buffer RAM contents need not be cleared.
- Packing: byte k occupies bits [8k+7:8k], with k = 3*row + col.
  - row 0 = oldest line (top), col 0 = oldest pixel (left).
  - Byte 8 is the newest pixel (bottom-right).
- States:
  - WAIT_SOF: valid pixels without i_sof are dropped. Valid pixel with i_sof is stored as (0,0); go to FILL.
  - FILL: rows 0-1 are written into the line buffers and no windows are emitted. At the end of row 1, go to STREAM.
  - STREAM: every accepted pixel at (r,c) with c>=2 yields one window centred at (r-1, c-1).
  - Transitions out of FILL/STREAM: the last pixel (IMG_HEIGHT-1, IMG_WIDTH-1) goes to WAIT_SOF.
- Counters advance only on i_pixels_valid. Gaps of any length are allowed and leave all state frozen.
- Column wraps IMG_WIDTH-1 -> 0 with row+1. At a row start, the 3-column shift window is reloaded so no window spans two lines.
- Line buffers: two per image, depth IMG_WIDTH, synchronous read. Read and write use the same address (col) in the same cycle; read-before-write semantics are required.
- Latency: a window is presented exactly 2 cycles after the accepting cycle of its bottom-right pixel. Outputs are registered; data is held until the next window, and valid is high only for that cycle.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2), centre columns 1..IMG_WIDTH-2, rows 1..IMG_HEIGHT-2.
- o_frame_done: pulses 2 cycles after the last pixel is accepted, coincident with the final window's valid.
- i_sof in FILL/STREAM (mid-frame):
  - The frame is aborted: that pixel becomes (0,0) and the state goes to FILL.
  - Any window already in the 2-cycle pipeline still emerges.
  - No o_frame_done is issued for the aborted frame.
- i_sof on the last pixel position: it is treated as a restart, not as the frame end.
- rst mid-frame: in-flight windows are discarded, outputs clear the next cycle, and the block returns to WAIT_SOF.
- No backpressure: the downstream stage must accept one window per cycle.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4; left pixel = 4r+c, right = left+100, i_sof on the first pixel, continuous valid. Required response:
  - Exactly 4 windows.
  - First window 2 cycles after pixel (2,2), with o_kernel1_data=0x0A0908060504020100, o_kernel2_data=0x6E6D6C6A6968666564, centre (1,1).
  - o_frame_done pulses with the 4th window, centre (2,2).
- Same frame with i_pixels_valid toggling 1/0 every other cycle and 3-cycle random gaps -> identical window data, coordinates and order; each window 2 cycles after its accepting cycle.
- 5 valid pixels without i_sof after reset, then the frame from the first scenario -> the 5 pixels are ignored and the output matches the first scenario exactly.
- i_sof reasserted at pixel (2,3) of the first frame, then a full frame with offset values -> the window from pixel (2,2) emerges; no frame_done for the aborted frame; the second frame yields 4 correct windows using only new data.
- rst held 1 cycle at pixel (3,1) -> o_kernels_valid stays 0 afterwards; all outputs are 0 the cycle after reset; the next frame with i_sof is processed correctly.
- Two back-to-back frames (i_sof on the cycle right after the last pixel) -> 8 windows and two o_frame_done pulses; second-frame data is uncontaminated by the first frame's line buffers.
